// File: rtl/rsa_pkg.sv
// RSA key-setup shared definitions: controller states, default sizes, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        RED,
        INV,
        KMUL,
        DIV,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 128;
    localparam int unsigned DEFAULT_E     = 65537;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          result;
        v      = (value > 0) ? value - 1 : 0;
        result = 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/modinv_small.sv
// Binary modular inverse y = r^-1 mod E for a small odd constant modulus E.
// Latency: one action per cycle after start, at most about 4*EW cycles, then a one-cycle done pulse.
// Backpressure: none; a new start restarts the loop, err is valid with done.
// Ports: clk, reset (async, active-high), start (pulse, samples r), r (EW),
//        done (pulse), err (gcd(r,E) != 1 or r == 0), y (EW, inverse when !err).
module modinv_small
    import rsa_pkg::*;
#(
    parameter int unsigned E  = DEFAULT_E,
    parameter int unsigned EW = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [EW-1:0] r,
    output logic          done,
    output logic          err,
    output logic [EW-1:0] y
);
    localparam logic [EW-1:0] E_V = EW'(E);
    localparam logic [EW:0]   E_X = (EW+1)'(E);

    logic [EW-1:0] u, v, x1, x2;
    logic          active;

    // x/2 mod E; an odd x is made even by adding the odd modulus first.
    function automatic logic [EW-1:0] half_mod(input logic [EW-1:0] x);
        return x[0] ? EW'(({1'b0, x} + E_X) >> 1) : (x >> 1);
    endfunction

    // (a - b) mod E for a, b already reduced.
    function automatic logic [EW-1:0] sub_mod(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return (a >= b) ? (a - b) : EW'({1'b0, a} + E_X - {1'b0, b});
    endfunction

    // Invariants: x1*r == u and x2*r == v (mod E).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u      <= '0;
            v      <= '0;
            x1     <= '0;
            x2     <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            y      <= '0;
        end else if (start) begin
            u      <= r;
            v      <= E_V;
            x1     <= EW'(1);
            x2     <= '0;
            active <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (active) begin
                if (u == EW'(1)) begin
                    y      <= x1;
                    done   <= 1'b1;
                    active <= 1'b0;
                end else if (v == EW'(1)) begin
                    y      <= x2;
                    done   <= 1'b1;
                    active <= 1'b0;
                end else if (u == '0 || v == '0) begin
                    // Reaching zero means a common factor (or r == 0).
                    err    <= 1'b1;
                    done   <= 1'b1;
                    active <= 1'b0;
                end else if (!u[0]) begin
                    u  <= u >> 1;
                    x1 <= half_mod(x1);
                end else if (!v[0]) begin
                    v  <= v >> 1;
                    x2 <= half_mod(x2);
                end else if (u >= v) begin
                    u  <= u - v;
                    x1 <= sub_mod(x1, x2);
                end else begin
                    v  <= v - u;
                    x2 <= sub_mod(x2, x1);
                end
            end
        end
    end

endmodule

// File: rtl/rsa_keygen.sv
// RSA key setup: n = p*q and d = E^-1 mod (p-1)(q-1), bit-serial.
// Latency: 1 + WIDTH + 2*WIDTH + INV + EW + (2*WIDTH+EW) + 1 cycles from start to finish.
// Backpressure: none; start is accepted in any state and aborts a run in progress.
// Ports: clk, reset (async, active-high), start (pulse), p/q (WIDTH, sampled on start),
//        n/d (2*WIDTH, valid with finish), busy, finish (level), error (qualified by finish).
module rsa_keygen
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned E     = DEFAULT_E,
    parameter int unsigned EW    = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] d,
    output logic               busy,
    output logic               finish,
    output logic               error
);
    localparam int unsigned   NW  = 2 * WIDTH;
    localparam int unsigned   TW  = NW + EW;
    localparam int unsigned   CW  = clog2(TW + 1);
    localparam logic [EW-1:0] E_V = EW'(E);
    localparam logic [EW:0]   E_X = (EW+1)'(E);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [WIDTH-1:0] p_r, q_sh, qm1_sh, pm1;
    logic [NW-1:0]   n_r, phi_r, phi_nxt, d_r;
    logic [EW-1:0]   r_r, k_sh, rem_r, red_nxt, rem_nxt;
    logic [EW:0]     red_sh, rem_sh;
    logic [TW-1:0]   t_r, add_a, add_b, add_s;
    logic            add_c, div_ge, err_r;
    logic            inv_start, inv_done, inv_err;
    logic [EW-1:0]   inv_y;

    assign busy   = (state != IDLE) && (state != DONE);
    assign finish = (state == DONE);
    assign n      = n_r;
    assign d      = d_r;
    assign error  = err_r;

    // Final cycle of each fixed-length phase.
    always_comb begin
        last = 1'b0;
        case (state)
            MUL:     last = (cnt == CW'(WIDTH - 1));
            RED:     last = (cnt == CW'(NW - 1));
            KMUL:    last = (cnt == CW'(EW - 1));
            DIV:     last = (cnt == CW'(TW - 1));
            default: last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = MUL;
        end else begin
            case (state)
                MUL:     if (last) state_nxt = RED;
                RED:     if (last) state_nxt = INV;
                INV:     if (inv_done) state_nxt = inv_err ? DONE : KMUL;
                KMUL:    if (last) state_nxt = DIV;
                DIV:     if (last) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // One adder serves the n multiply, the k*phi multiply and the divider's trial subtract.
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_c = 1'b0;
        case (state)
            MUL: begin
                add_a = TW'({n_r[NW-2:0], 1'b0});
                add_b = q_sh[WIDTH-1] ? TW'(p_r) : '0;
            end
            KMUL: begin
                add_a = {t_r[TW-2:0], 1'b0};
                add_b = k_sh[EW-1] ? TW'(phi_r) : '0;
                add_c = last;               // folds the "+1" of t = 1 + k*phi into the last step
            end
            DIV: begin
                add_a = TW'(rem_sh);
                add_b = ~TW'(E_V);          // with add_c: rem_sh - E, sign in the MSB
                add_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_s   = add_a + add_b + TW'(add_c);
    assign pm1     = p_r - WIDTH'(1);
    assign phi_nxt = {phi_r[NW-2:0], 1'b0} + (qm1_sh[WIDTH-1] ? NW'(pm1) : '0);
    assign red_sh  = {r_r, phi_r[NW-1]};
    assign red_nxt = (red_sh >= E_X) ? EW'(red_sh - E_X) : EW'(red_sh);
    assign rem_sh  = {rem_r, t_r[TW-1]};
    assign div_ge  = ~add_s[TW-1];
    assign rem_nxt = div_ge ? add_s[EW-1:0] : rem_sh[EW-1:0];

    assign inv_start = (state == RED) && last && !start;

    modinv_small #(.E(E), .EW(EW)) u_inv (
        .clk   (clk),
        .reset (reset),
        .start (inv_start),
        .r     (red_nxt),
        .done  (inv_done),
        .err   (inv_err),
        .y     (inv_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            p_r    <= '0;
            q_sh   <= '0;
            qm1_sh <= '0;
            n_r    <= '0;
            phi_r  <= '0;
            r_r    <= '0;
            k_sh   <= '0;
            t_r    <= '0;
            rem_r  <= '0;
            d_r    <= '0;
            err_r  <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            p_r    <= p;
            q_sh   <= q;
            qm1_sh <= q - WIDTH'(1);
            n_r    <= '0;
            phi_r  <= '0;
            r_r    <= '0;
            k_sh   <= '0;
            t_r    <= '0;
            rem_r  <= '0;
            d_r    <= '0;
            err_r  <= 1'b0;
        end else begin
            if (last)                      cnt <= '0;
            else if (busy && state != INV) cnt <= cnt + CW'(1);

            case (state)
                MUL: begin
                    // MSB-first shift-add over the multiplier bits of q and q-1.
                    n_r    <= add_s[NW-1:0];
                    phi_r  <= phi_nxt;
                    q_sh   <= q_sh << 1;
                    qm1_sh <= qm1_sh << 1;
                end
                RED: begin
                    // Rotating phi exposes its bits MSB-first and restores it after NW cycles.
                    r_r   <= red_nxt;
                    phi_r <= {phi_r[NW-2:0], phi_r[NW-1]};
                end
                INV: begin
                    if (inv_done) begin
                        if (inv_err)          err_r <= 1'b1;
                        else if (inv_y == '0) k_sh  <= '0;
                        else                  k_sh  <= E_V - inv_y;
                    end
                end
                KMUL: begin
                    t_r  <= add_s;
                    k_sh <= k_sh << 1;
                end
                DIV: begin
                    // Restoring divide: quotient bits shift into t from the bottom.
                    rem_r <= rem_nxt;
                    t_r   <= {t_r[TW-2:0], div_ge};
                    if (last) begin
                        d_r <= {t_r[NW-2:0], div_ge};
                        if (rem_nxt != '0) err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_keygen.sv
module tb_rsa_keygen;
    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b, start_c, start_d;
    logic [7:0]   p_a, q_a, p_b, q_b, p_c, q_c;
    logic [127:0] p_d, q_d;
    logic [15:0]  n_a, d_a, n_b, d_b, n_c, d_c;
    logic [255:0] n_d, d_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic finish_a, finish_b, finish_c, finish_d;
    logic error_a, error_b, error_c, error_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rsa_keygen #(.WIDTH(8), .E(17), .EW(5)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .p(p_a), .q(q_a), .n(n_a), .d(d_a),
        .busy(busy_a), .finish(finish_a), .error(error_a));
    rsa_keygen #(.WIDTH(8), .E(65537), .EW(17)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .p(p_b), .q(q_b), .n(n_b), .d(d_b),
        .busy(busy_b), .finish(finish_b), .error(error_b));
    rsa_keygen #(.WIDTH(8), .E(3), .EW(2)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .p(p_c), .q(q_c), .n(n_c), .d(d_c),
        .busy(busy_c), .finish(finish_c), .error(error_c));
    rsa_keygen #(.WIDTH(128), .E(65537), .EW(17)) u_d (
        .clk(clk), .reset(reset), .start(start_d), .p(p_d), .q(q_d), .n(n_d), .d(d_d),
        .busy(busy_d), .finish(finish_d), .error(error_d));

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Extended Euclid: a^-1 mod m.
    function automatic logic [511:0] inv_mod(input logic [511:0] a, input logic [511:0] m);
        logic [511:0] old_r, r, old_s, s, qt, tmp;
        int guard;
        old_r = a; r = m; old_s = 1; s = 0; guard = 0;
        while (r != 0 && guard < 4000) begin
            qt    = old_r / r;
            tmp   = r;
            r     = old_r - qt * r;
            old_r = tmp;
            tmp   = s;
            s     = (old_s + m - (qt * s) % m) % m;
            old_s = tmp;
            guard++;
        end
        return old_s;
    endfunction

    initial begin
        int cyc, lat_a, lat_a2, busy_cnt, gap, unstable;
        bit fa, fb, fc, fd;
        logic [511:0] phi_full, d_model;

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        p_a = '0; q_a = '0; p_b = '0; q_b = '0; p_c = '0; q_c = '0; p_d = '0; q_d = '0;
        repeat (3) @(negedge clk);

        check("rst_n", n_a, 0);
        check("rst_d", d_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_finish", finish_a, 0);
        check("rst_error", error_a, 0);
        check("rst_n_full", n_d, 0);

        reset = 1'b0;
        @(negedge clk);

        // All four configurations in parallel.
        p_a = 8'd61; q_a = 8'd53;
        p_b = 8'd11; q_b = 8'd13;
        p_c = 8'd7;  q_c = 8'd11;
        p_d = 128'd8475698667747010771; q_d = 128'd11297384090418420749;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        cyc = 1; fa = 0; fb = 0; fc = 0; fd = 0; busy_cnt = 0; gap = 0; lat_a = 0;
        while (cyc < 3000 && !(fa && fb && fc && fd)) begin
            if (!fa) begin
                if (finish_a)    begin fa = 1; lat_a = cyc; end
                else if (busy_a) busy_cnt++;
                else             gap++;
            end
            if (finish_b) fb = 1;
            if (finish_c) fc = 1;
            if (finish_d) fd = 1;
            @(negedge clk);
            cyc++;
        end

        check("a_finish", fa, 1);
        check("a_n", n_a, 3233);
        check("a_d", d_a, 2753);
        check("a_error", error_a, 0);
        check("a_busy_gap", gap, 0);
        check("a_latency_vs_busy", lat_a, busy_cnt + 1);
        check("a_busy_range", (busy_cnt >= 51 && busy_cnt <= 70), 1);
        check("a_busy_done", busy_a, 0);

        check("b_finish", fb, 1);
        check("b_n", n_b, 143);
        check("b_d", d_b, 113);
        check("b_error", error_b, 0);

        check("c_finish", fc, 1);
        check("c_error", error_c, 1);

        phi_full = 512'(p_d - 128'd1) * 512'(q_d - 128'd1);
        d_model  = inv_mod(512'd65537, phi_full);
        check("d_finish", fd, 1);
        check("d_error", error_d, 0);
        check("d_n", 512'(n_d), 512'(p_d) * 512'(q_d));
        check("d_d", 512'(d_d), d_model);
        check("d_inverse", (512'(d_d) * 512'd65537) % phi_full, 1);
        check("d_below_phi", 512'(d_d) < phi_full, 1);

        // Result holds with no start.
        unstable = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(finish_a === 1'b1 && n_a === 16'd3233 && d_a === 16'd2753 && busy_a === 1'b0))
                unstable++;
        end
        check("a_hold", unstable, 0);

        // Start from DONE, then abort mid-divide with a second start.
        p_a = 8'd13; q_a = 8'd11;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_finish", finish_a, 0);
        check("restart_d", d_a, 0);
        check("restart_busy", busy_a, 1);
        repeat (44) @(negedge clk);
        check("abort_prefinish", finish_a, 0);
        p_a = 8'd61; q_a = 8'd53;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1; fa = 0; lat_a2 = 0;
        while (cyc < 3000 && !fa) begin
            if (finish_a) begin fa = 1; lat_a2 = cyc; end
            else begin @(negedge clk); cyc++; end
        end
        check("abort_finish", fa, 1);
        check("abort_latency", lat_a2, lat_a);
        check("abort_n", n_a, 3233);
        check("abort_d", d_a, 2753);
        check("abort_error", error_a, 0);

        // Reset in the middle of the multiply.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_n", n_a, 0);
        check("midrst_d", d_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_finish", finish_a, 0);
        check("midrst_error", error_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", busy_a, 0);
        check("idle_finish", finish_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
